// File: rtl/eth_tx_arbiter.sv
// Frame-level arbiter that shares the MAC TX byte stream between the ARP reply
// generator and the UDP transmit path, with stall abort/flush and inter-frame gap.
module eth_tx_arbiter #(
  parameter int ARP_PRIORITY = 1,
  parameter int IFG_CYCLES   = 12,
  parameter int STALL_LIMIT  = 64
) (
  input  logic       clk_in,
  input  logic       rstn_in,
  input  logic [7:0] arp_tdata_in,
  input  logic       arp_tvalid_in,
  input  logic       arp_tlast_in,
  output logic       arp_tready_out,
  input  logic [7:0] udp_tdata_in,
  input  logic       udp_tvalid_in,
  input  logic       udp_tlast_in,
  output logic       udp_tready_out,
  output logic [7:0] mac_tdata_out,
  output logic       mac_tvalid_out,
  output logic       mac_tlast_out,
  output logic       mac_tuser_out,
  input  logic       mac_tready_in,
  output logic [1:0] grant_out,
  output logic [7:0] abort_cnt_out
);

  localparam logic [7:0]  IFG_LEN   = 8'(IFG_CYCLES);
  localparam logic [15:0] STALL_MAX = 16'(STALL_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARP   = 3'd1,
    S_UDP   = 3'd2,
    S_ABORT = 3'd3,
    S_FLUSH = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic        owner_udp_reg, owner_udp_next;   // 1 = UDP owns the frame
  logic        rr_udp_reg, rr_udp_next;         // 1 = UDP was served last
  logic [15:0] stall_cnt_reg, stall_cnt_next;
  logic [7:0]  gap_cnt_reg, gap_cnt_next;
  logic [7:0]  abort_cnt_reg, abort_cnt_next;

  logic [7:0]  src_tdata;
  logic        src_tvalid;
  logic        src_tlast;
  logic        grant_udp;
  state_t      frame_end_state;

  assign src_tdata       = owner_udp_reg ? udp_tdata_in  : arp_tdata_in;
  assign src_tvalid      = owner_udp_reg ? udp_tvalid_in : arp_tvalid_in;
  assign src_tlast       = owner_udp_reg ? udp_tlast_in  : arp_tlast_in;
  assign frame_end_state = (IFG_LEN == 8'd0) ? S_IDLE : S_GAP;

  // Contention goes to ARP under fixed priority, otherwise to whoever was not served last.
  always_comb begin
    grant_udp = udp_tvalid_in;
    if (arp_tvalid_in && udp_tvalid_in)
      grant_udp = (ARP_PRIORITY == 0) ? !rr_udp_reg : 1'b0;
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_reg     <= S_IDLE;
      owner_udp_reg <= 1'b0;
      rr_udp_reg    <= 1'b0;
      stall_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
      abort_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_udp_reg <= owner_udp_next;
      rr_udp_reg    <= rr_udp_next;
      stall_cnt_reg <= stall_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      abort_cnt_reg <= abort_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_udp_next = owner_udp_reg;
    rr_udp_next    = rr_udp_reg;
    stall_cnt_next = stall_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    abort_cnt_next = abort_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        stall_cnt_next = '0;
        if (arp_tvalid_in || udp_tvalid_in) begin
          owner_udp_next = grant_udp;
          rr_udp_next    = grant_udp;
          state_next     = grant_udp ? S_UDP : S_ARP;
        end
      end
      S_ARP, S_UDP: begin
        // A completing tlast beat takes precedence over a stall abort.
        if (src_tvalid && mac_tready_in && src_tlast) begin
          state_next   = frame_end_state;
          gap_cnt_next = '0;
        end else if (stall_cnt_reg >= STALL_MAX) begin
          state_next = S_ABORT;
        end else begin
          stall_cnt_next = src_tvalid ? 16'd0 : stall_cnt_reg + 16'd1;
        end
      end
      S_ABORT: begin
        if (mac_tready_in) begin
          if (abort_cnt_reg != 8'hFF)
            abort_cnt_next = abort_cnt_reg + 8'd1;
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (src_tvalid && src_tlast) begin
          state_next   = frame_end_state;
          gap_cnt_next = '0;
        end
      end
      S_GAP: begin
        gap_cnt_next = gap_cnt_reg + 8'd1;
        if (gap_cnt_reg == IFG_LEN - 8'd1)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mac_tdata_out  = 8'h00;
    mac_tvalid_out = 1'b0;
    mac_tlast_out  = 1'b0;
    mac_tuser_out  = 1'b0;
    arp_tready_out = 1'b0;
    udp_tready_out = 1'b0;
    grant_out      = 2'b00;
    case (state_reg)
      S_ARP, S_UDP: begin
        mac_tdata_out  = src_tdata;
        mac_tvalid_out = src_tvalid;
        mac_tlast_out  = src_tlast;
        arp_tready_out = !owner_udp_reg && mac_tready_in;
        udp_tready_out = owner_udp_reg && mac_tready_in;
        grant_out      = owner_udp_reg ? 2'b10 : 2'b01;
      end
      S_ABORT: begin
        mac_tvalid_out = 1'b1;
        mac_tlast_out  = 1'b1;
        mac_tuser_out  = 1'b1;
        grant_out      = owner_udp_reg ? 2'b10 : 2'b01;
      end
      S_FLUSH: begin
        arp_tready_out = !owner_udp_reg;
        udp_tready_out = owner_udp_reg;
        grant_out      = owner_udp_reg ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  assign abort_cnt_out = abort_cnt_reg;

endmodule
